// File: rtl/pitch_pkg.sv
// Shared types and pitch-range constants for the note selector.
package pitch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_e;

  localparam logic [3:0] NOTE_MAX = 4'd11;
  localparam logic [2:0] OCT_MIN  = 3'd2;
  localparam logic [2:0] OCT_MAX  = 3'd6;
  localparam logic [3:0] RST_NOTE = 4'd9;
  localparam logic [2:0] RST_OCT  = 3'd4;

endpackage

// File: rtl/note_step.sv
// Combinational one-semitone step with octave carry/borrow, saturating at the
// ends of the supported pitch range. Opposing requests cancel.
module note_step
  import pitch_pkg::*;
(
  input  logic [3:0] note,
  input  logic [2:0] oct,
  input  logic       up,
  input  logic       dn,
  output logic [3:0] note_nxt,
  output logic [2:0] oct_nxt
);

  always_comb begin
    note_nxt = note;
    oct_nxt  = oct;
    if (up && !dn) begin
      if (note >= NOTE_MAX) begin
        if (oct < OCT_MAX) begin
          note_nxt = 4'd0;
          oct_nxt  = oct + 3'd1;
        end
      end else begin
        note_nxt = note + 4'd1;
      end
    end else if (dn && !up) begin
      if (note == 4'd0) begin
        if (oct > OCT_MIN) begin
          note_nxt = NOTE_MAX;
          oct_nxt  = oct - 3'd1;
        end
      end else begin
        note_nxt = note - 4'd1;
      end
    end
  end

endmodule

// File: rtl/note_sel_ctrl.sv
// Target-note selector: centre button toggles IDLE/EDIT, up/down step the edit pitch.
// Optional macro EDIT_TIMEOUT_EN adds an inactivity auto-abort in EDIT.
module note_sel_ctrl
  import pitch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned TO_W        = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_c_n,
  input  logic       btn_u_n,
  input  logic       btn_d_n,
  output logic       editing,
  output logic [3:0] tgt_note,
  output logic [2:0] tgt_oct,
  output logic [3:0] disp_note,
  output logic [2:0] disp_oct,
  output logic       commit
);

  if (64'(TIMEOUT_CYC) >= (64'd1 << TO_W)) begin : g_to_w_check
    $error("TO_W too narrow to hold TIMEOUT_CYC");
  end

  logic ev_c, ev_u, ev_d;
  assign ev_c = ~btn_c_n;
  assign ev_u = ~btn_u_n;
  assign ev_d = ~btn_d_n;

  state_e     state_q, state_d;
  logic [3:0] tgt_note_q, tgt_note_d, edit_note_q, edit_note_d, disp_note_q, disp_note_d;
  logic [2:0] tgt_oct_q, tgt_oct_d, edit_oct_q, edit_oct_d, disp_oct_q, disp_oct_d;
  logic       commit_q, commit_d;
  logic [3:0] step_note;
  logic [2:0] step_oct;

  note_step u_step (
    .note     (edit_note_q),
    .oct      (edit_oct_q),
    .up       (ev_u),
    .dn       (ev_d),
    .note_nxt (step_note),
    .oct_nxt  (step_oct)
  );

`ifdef EDIT_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
`endif

  always_comb begin
    state_d     = state_q;
    tgt_note_d  = tgt_note_q;
    tgt_oct_d   = tgt_oct_q;
    edit_note_d = edit_note_q;
    edit_oct_d  = edit_oct_q;
    commit_d    = 1'b0;
`ifdef EDIT_TIMEOUT_EN
    to_d        = to_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef EDIT_TIMEOUT_EN
        to_d = '0;
`endif
        if (ev_c) begin
          edit_note_d = tgt_note_q;
          edit_oct_d  = tgt_oct_q;
          state_d     = EDIT;
        end
      end
      EDIT: begin
        if (ev_c) begin
          // Commit wins over both stepping and a coincident timeout expiry.
          tgt_note_d = edit_note_q;
          tgt_oct_d  = edit_oct_q;
          commit_d   = 1'b1;
          state_d    = IDLE;
        end else begin
          edit_note_d = step_note;
          edit_oct_d  = step_oct;
`ifdef EDIT_TIMEOUT_EN
          if (ev_u || ev_d) begin
            to_d = '0;
          end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
            to_d    = '0;
            state_d = IDLE;
          end else begin
            to_d = to_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Display is registered alongside the state it reflects.
    if (state_d == EDIT) begin
      disp_note_d = edit_note_d;
      disp_oct_d  = edit_oct_d;
    end else begin
      disp_note_d = tgt_note_d;
      disp_oct_d  = tgt_oct_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tgt_note_q  <= RST_NOTE;
      tgt_oct_q   <= RST_OCT;
      edit_note_q <= RST_NOTE;
      edit_oct_q  <= RST_OCT;
      disp_note_q <= RST_NOTE;
      disp_oct_q  <= RST_OCT;
      commit_q    <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tgt_note_q  <= tgt_note_d;
      tgt_oct_q   <= tgt_oct_d;
      edit_note_q <= edit_note_d;
      edit_oct_q  <= edit_oct_d;
      disp_note_q <= disp_note_d;
      disp_oct_q  <= disp_oct_d;
      commit_q    <= commit_d;
`ifdef EDIT_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  assign editing   = (state_q == EDIT);
  assign tgt_note  = tgt_note_q;
  assign tgt_oct   = tgt_oct_q;
  assign disp_note = disp_note_q;
  assign disp_oct  = disp_oct_q;
  assign commit    = commit_q;

endmodule

// File: tb/tb_note_sel_ctrl.sv
// Scoreboard bench for note_sel_ctrl: driver pushes expected outputs per cycle,
// monitor pops and compares one cycle later. Timeout cases need EDIT_TIMEOUT_EN.
module tb_note_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_c_n = 1'b1, btn_u_n = 1'b1, btn_d_n = 1'b1;
  logic       editing, commit;
  logic [3:0] tgt_note, disp_note;
  logic [2:0] tgt_oct, disp_oct;

  note_sel_ctrl #(
    .TIMEOUT_CYC (16),
    .TO_W        (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_c_n   (btn_c_n),
    .btn_u_n   (btn_u_n),
    .btn_d_n   (btn_d_n),
    .editing   (editing),
    .tgt_note  (tgt_note),
    .tgt_oct   (tgt_oct),
    .disp_note (disp_note),
    .disp_oct  (disp_oct),
    .commit    (commit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       editing;
    logic [3:0] tn;
    logic [2:0] to;
    logic [3:0] dn;
    logic [2:0] dox;
    logic       commit;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   dut_commits = 0;

  // Model keeps pitch as a linear semitone index: oct*12 + note (A4 = 57).
  bit m_edit = 0;
  bit m_commit = 0;
  int m_tgt = 57;
  int m_ed = 57;
  int m_quiet = 0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit u, input bit d);
    exp_t e;
    int   disp;
    @(negedge clk);
    rst = r;
    btn_c_n = ~c;
    btn_u_n = ~u;
    btn_d_n = ~d;
    m_commit = 0;
    if (r) begin
      m_edit = 0; m_tgt = 57; m_ed = 57; m_quiet = 0;
    end else if (!m_edit) begin
      if (c) begin
        m_ed = m_tgt; m_edit = 1; m_quiet = 0;
      end
    end else if (c) begin
      m_tgt = m_ed; m_commit = 1; m_edit = 0;
    end else begin
      if (u && !d && m_ed < 83) m_ed++;
      else if (d && !u && m_ed > 24) m_ed--;
`ifdef EDIT_TIMEOUT_EN
      if (u || d) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == 16) m_edit = 0;
      end
`endif
    end
    disp = m_edit ? m_ed : m_tgt;
    e.editing = m_edit;
    e.tn = 4'(m_tgt % 12);
    e.to = 3'(m_tgt / 12);
    e.dn = 4'(disp % 12);
    e.dox = 3'(disp / 12);
    e.commit = m_commit;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  // Monitor: outputs are registered, so compare just after each rising edge.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (commit === 1'b1) dut_commits++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {editing, tgt_note, tgt_oct, disp_note, disp_oct, commit};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got ed=%b tgt=%0d/%0d disp=%0d/%0d c=%b, want ed=%b tgt=%0d/%0d disp=%0d/%0d c=%b",
                 $time, a.editing, a.tn, a.to, a.dn, a.dox, a.commit,
                 e.editing, e.tn, e.to, e.dn, e.dox, e.commit);
      end
    end
  end

  initial begin
    int want_commits;
    want_commits = 0;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    idle(10);
    @(negedge clk);
    check("reset tgt_note", int'(tgt_note), 9);
    check("reset tgt_oct", int'(tgt_oct), 4);
    check("reset editing", int'(editing), 0);
    check("reset commits", dut_commits, 0);

    // A4 + 3 semitones = C5
    drive(0, 1, 0, 0);
    repeat (3) drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    idle(2);
    want_commits++;
    @(negedge clk);
    check("c-u3-c tgt_note", int'(tgt_note), 0);
    check("c-u3-c tgt_oct", int'(tgt_oct), 5);
    check("c-u3-c commits", dut_commits, 1);

    // c beats u in the same cycle: commit C#5 (one u before)
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 1, 1, 0);
    idle(2);
    want_commits++;
    @(negedge clk);
    check("c priority tgt_note", int'(tgt_note), 1);
    check("c priority tgt_oct", int'(tgt_oct), 5);

    // Down-saturate at C2, u+d together is a no-op
    drive(0, 1, 0, 0);
    repeat (60) drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    @(negedge clk);
    check("low sat disp_note", int'(disp_note), 0);
    check("low sat disp_oct", int'(disp_oct), 2);
    drive(0, 1, 0, 0);
    idle(1);
    want_commits++;
    @(negedge clk);
    check("low sat tgt_oct", int'(tgt_oct), 2);

    // Up-saturate at B6
    drive(0, 1, 0, 0);
    repeat (70) drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    idle(1);
    want_commits++;
    @(negedge clk);
    check("high sat tgt_note", int'(tgt_note), 11);
    check("high sat tgt_oct", int'(tgt_oct), 6);

    // Reset mid-edit, with a coincident c, discards edits without commit
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    drive(1, 1, 0, 0);
    idle(3);
    @(negedge clk);
    check("rst in edit tgt_note", int'(tgt_note), 9);
    check("rst in edit tgt_oct", int'(tgt_oct), 4);
    check("rst in edit editing", int'(editing), 0);

    // u/d in IDLE are ignored
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    idle(2);
    @(negedge clk);
    check("idle ud tgt_note", int'(tgt_note), 9);
    check("idle ud disp_oct", int'(disp_oct), 4);

`ifdef EDIT_TIMEOUT_EN
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    idle(15);
    @(negedge clk);
    check("timeout pre editing", int'(editing), 1);
    idle(1);
    @(negedge clk);
    check("timeout editing", int'(editing), 0);
    check("timeout tgt_note", int'(tgt_note), 9);

    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    idle(15);
    drive(0, 1, 0, 0);
    idle(1);
    want_commits++;
    @(negedge clk);
    check("c at expiry tgt_note", int'(tgt_note), 10);
`endif

    idle(2);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard drained", sb_q.size(), 0);
    check("total commits", dut_commits, want_commits);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/note_sel_ctrl.md
NOTE_SEL_CTRL -- requirements
Module: note_sel_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 500_000_000: idle cycles in EDIT before auto-abort (used only with EDIT_TIMEOUT_EN).
REQ-002 SHALL have parameter TO_W, default 29: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_c_n  in  1  centre-button event: active-low, one-cycle pulse from button conditioning stage.
REQ-006 SHALL have port btn_u_n  in  1  up-button event: active-low, one-cycle pulse.
REQ-007 SHALL have port btn_d_n  in  1  down-button event: active-low, one-cycle pulse.
REQ-008 SHALL have port editing  out  1  high while FSM in EDIT.
REQ-009 SHALL have port tgt_note  out  4  committed target note index, 0..11 (0=C, 9=A).
REQ-010 SHALL have port tgt_oct  out  3  committed target octave, 2..6.
REQ-011 SHALL have port disp_note  out  4  tgt_note in IDLE; edit_note in EDIT.
REQ-012 SHALL have port disp_oct  out  3  tgt_oct in IDLE; edit_oct in EDIT.
REQ-013 SHALL have port commit  out  1  one-cycle pulse when a new target is committed.

Function
REQ-014 SHALL decode events as c=~btn_c_n, u=~btn_u_n, d=~btn_d_n, sampled each clk.
REQ-015 SHALL implement FSM states IDLE and EDIT; all outputs registered, responding one cycle after the sampled event.
REQ-016 IDLE + c: SHALL copy tgt_note/tgt_oct into edit_note/edit_oct and enter EDIT; u/d in IDLE SHALL be ignored.
REQ-017 EDIT + c: SHALL write edit_* into tgt_*, pulse commit for exactly one cycle, return to IDLE.
REQ-018 EDIT + u: edit_note+1; 11 -> 0 with edit_oct+1; at note 11 octave 6 SHALL hold (saturate, no wrap).
REQ-019 EDIT + d: edit_note-1; 0 -> 11 with edit_oct-1; at note 0 octave 2 SHALL hold.
REQ-020 Simultaneous events: c SHALL take priority over u/d; u and d together without c SHALL cause no change.
REQ-021 Edit values SHALL never leave note 0..11, octave 2..6 under any input sequence.
REQ-022 commit SHALL be low in every cycle except the one following an EDIT+c event.

Reset
REQ-023 rst SHALL force state IDLE, tgt_note=9, tgt_oct=4 (A4), edit_note=9, edit_oct=4, commit=0, editing=0, timeout counter=0.
REQ-024 rst asserted during EDIT SHALL discard edits without a commit pulse; rst SHALL win over any same-cycle event.

Configuration
REQ-025 With macro EDIT_TIMEOUT_EN defined: counter SHALL clear on entry to EDIT and on every u/d event, increment each EDIT cycle, and on reaching TIMEOUT_CYC-1 return to IDLE, discarding edits with no commit.
REQ-026 A c event in the same cycle as timeout expiry SHALL take priority (commit).
REQ-027 Without EDIT_TIMEOUT_EN: no counter logic SHALL be present; EDIT persists until c or rst.

Structure
REQ-028 A shared package pitch_pkg SHALL hold the state typedef (IDLE, EDIT), NOTE_MAX=11, OCT_MIN=2, OCT_MAX=6, RST_NOTE=9, RST_OCT=4.
REQ-029 Sub-module note_step (combinational inc/dec with octave carry and saturation) SHALL implement REQ-018/019.

Verification
REQ-030 rst then idle 10 cycles -> tgt=9/4, disp=9/4, editing=0, commit never asserted.
REQ-031 c, u x3, c -> editing 1 then 0; tgt_note=0, tgt_oct=5; commit exactly one cycle.
REQ-032 Enter EDIT, d x60 from A4 -> saturate at note 0 oct 2; u with d same cycle -> no change.
REQ-033 Enter EDIT, u, then rst -> tgt=9/4, editing=0, no commit pulse.
REQ-034 EDIT_TIMEOUT_EN, TIMEOUT_CYC=16: enter EDIT, u, wait 16 cycles -> IDLE, tgt unchanged, no commit; c on expiry cycle -> commit.
REQ-035 IDLE, u and d pulses only -> all outputs unchanged.
